// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: the ID-side fields and their registered EX-side copies.
// The master drives the ID side and observes EX; the slave is the pipeline register.
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic [5:0]        id_opcode;
    logic              id_reg_dst, id_branch, id_mem_read, id_mem_to_reg;
    logic              id_mem_write, id_alu_src, id_reg_write;
    logic [1:0]        id_alu_op;
    logic [DATA_W-1:0] id_pc4, id_rd1, id_rd2, id_imm;
    logic [REG_W-1:0]  id_rs, id_rt, id_rd;

    logic              ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg;
    logic              ex_mem_write, ex_alu_src, ex_reg_write;
    logic [1:0]        ex_alu_op;
    logic [DATA_W-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [REG_W-1:0]  ex_rs, ex_rt, ex_rd;
    logic              ex_illegal;

    modport master (
        output id_opcode, id_reg_dst, id_branch, id_mem_read, id_mem_to_reg,
               id_mem_write, id_alu_src, id_reg_write, id_alu_op,
               id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
        input  ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg,
               ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op,
               ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_illegal
    );

    modport slave (
        input  id_opcode, id_reg_dst, id_branch, id_mem_read, id_mem_to_reg,
               id_mem_write, id_alu_src, id_reg_write, id_alu_op,
               id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
        output ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg,
               ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op,
               ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_illegal
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch squash,
// illegal-opcode-to-NOP conversion and a saturating bubble counter.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    id_ex_if.slave           bus,
    input  logic             flush,
    input  logic             stat_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic [CNT_W-1:0] stall_count
);
    localparam logic [5:0] MAX_OPCODE = 6'd12;

    logic hazard;
    logic stall;
    logic illegal;
    logic load_ctrl;

    // Both ID specifiers are compared even when rt is a destination: a spare
    // bubble is cheaper than decoding which instructions really read rt.
    always_comb begin
        hazard     = bus.ex_mem_read && (bus.ex_rt != '0) &&
                     ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));
        stall      = hazard && !flush;
        pc_write   = !stall;
        ifid_write = !stall;
        illegal    = bus.id_opcode > MAX_OPCODE;
        load_ctrl  = !flush && !hazard && !illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_reg_dst    <= 1'b0;
            bus.ex_branch     <= 1'b0;
            bus.ex_mem_read   <= 1'b0;
            bus.ex_mem_to_reg <= 1'b0;
            bus.ex_mem_write  <= 1'b0;
            bus.ex_alu_src    <= 1'b0;
            bus.ex_reg_write  <= 1'b0;
            bus.ex_alu_op     <= 2'b00;
            bus.ex_pc4        <= '0;
            bus.ex_rd1        <= '0;
            bus.ex_rd2        <= '0;
            bus.ex_imm        <= '0;
            bus.ex_rs         <= '0;
            bus.ex_rt         <= '0;
            bus.ex_rd         <= '0;
            bus.ex_illegal    <= 1'b0;
            stall_count       <= '0;
        end else begin
            // Datapath fields always advance; a zero control word makes them inert.
            bus.ex_pc4        <= bus.id_pc4;
            bus.ex_rd1        <= bus.id_rd1;
            bus.ex_rd2        <= bus.id_rd2;
            bus.ex_imm        <= bus.id_imm;
            bus.ex_rs         <= bus.id_rs;
            bus.ex_rt         <= bus.id_rt;
            bus.ex_rd         <= bus.id_rd;
            bus.ex_reg_dst    <= load_ctrl && bus.id_reg_dst;
            bus.ex_branch     <= load_ctrl && bus.id_branch;
            bus.ex_mem_read   <= load_ctrl && bus.id_mem_read;
            bus.ex_mem_to_reg <= load_ctrl && bus.id_mem_to_reg;
            bus.ex_mem_write  <= load_ctrl && bus.id_mem_write;
            bus.ex_alu_src    <= load_ctrl && bus.id_alu_src;
            bus.ex_reg_write  <= load_ctrl && bus.id_reg_write;
            bus.ex_alu_op     <= load_ctrl ? bus.id_alu_op : 2'b00;
            bus.ex_illegal    <= !flush && !hazard && illegal;
            if (stat_clr) begin
                stall_count <= '0;
            end else if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Randomised and directed bench for id_ex_stage against a slot-level model of
// what instruction (if any) occupies EX and how many bubbles have been inserted.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_if bus ();
    id_ex_if bus_s ();

    logic        flush, stat_clr, pc_write, ifid_write;
    logic [15:0] stall_count;
    logic        flush_s, stat_clr_s, pc_write_s, ifid_write_s;
    logic [2:0]  stall_count_s;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush), .stat_clr(stat_clr),
        .pc_write(pc_write), .ifid_write(ifid_write), .stall_count(stall_count)
    );

    // Narrow-counter copy: a permanently dependent load in ID drives it to saturation quickly.
    id_ex_stage #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus_s), .flush(flush_s), .stat_clr(stat_clr_s),
        .pc_write(pc_write_s), .ifid_write(ifid_write_s), .stall_count(stall_count_s)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected contents of the EX slot and the bubble tally.
    logic [8:0]  m_ctrl;
    logic        m_ill;
    logic [31:0] m_pc4, m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;
    int          m_cnt;

    // {reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op[1:0]}
    localparam logic [8:0] C_LW    = 9'b0_0_1_1_0_1_1_00;
    localparam logic [8:0] C_ADD   = 9'b1_0_0_0_0_0_1_10;
    localparam logic [8:0] C_ITYPE = 9'b0_0_0_0_0_1_1_10;

    function automatic logic [8:0] id_word();
        return {bus.id_reg_dst, bus.id_branch, bus.id_mem_read, bus.id_mem_to_reg,
                bus.id_mem_write, bus.id_alu_src, bus.id_reg_write, bus.id_alu_op};
    endfunction

    function automatic logic [8:0] ex_word();
        return {bus.ex_reg_dst, bus.ex_branch, bus.ex_mem_read, bus.ex_mem_to_reg,
                bus.ex_mem_write, bus.ex_alu_src, bus.ex_reg_write, bus.ex_alu_op};
    endfunction

    function automatic bit load_waits();
        return m_ctrl[6] && (m_rt != 0) && (m_rt == bus.id_rs || m_rt == bus.id_rt);
    endfunction

    task automatic model_reset();
        m_ctrl = '0; m_ill = 1'b0; m_cnt = 0;
        m_pc4 = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
        m_rs = '0; m_rt = '0; m_rd = '0;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [8:0] c, input logic [4:0] rs,
                             input logic [4:0] rt, input logic [4:0] rd,
                             input logic [31:0] rd1, input logic [31:0] imm);
        bus.id_opcode = op;
        {bus.id_reg_dst, bus.id_branch, bus.id_mem_read, bus.id_mem_to_reg,
         bus.id_mem_write, bus.id_alu_src, bus.id_reg_write, bus.id_alu_op} = c;
        bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_rd1 = rd1; bus.id_imm = imm;
        bus.id_rd2 = $urandom; bus.id_pc4 = $urandom;
    endtask

    task automatic rand_instr();
        set_instr(6'($urandom_range(0, 20)), 9'($urandom), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom), $urandom, $urandom);
    endtask

    // Inputs are driven at the falling edge; comb outputs checked before the
    // rising edge, registered outputs 1 ns after it.
    task automatic cycle();
        bit waits;
        #1;
        waits = load_waits() && !flush;
        chk("pc_write", pc_write, !waits);
        chk("ifid_write", ifid_write, !waits);
        @(posedge clk);
        m_pc4 = bus.id_pc4; m_rd1 = bus.id_rd1; m_rd2 = bus.id_rd2; m_imm = bus.id_imm;
        m_rs = bus.id_rs; m_rt = bus.id_rt; m_rd = bus.id_rd;
        if (flush || waits) begin
            m_ctrl = '0; m_ill = 1'b0;
            if (waits && m_cnt < 65535) m_cnt++;
        end else if (bus.id_opcode > 12) begin
            m_ctrl = '0; m_ill = 1'b1;
        end else begin
            m_ctrl = id_word(); m_ill = 1'b0;
        end
        if (stat_clr) m_cnt = 0;
        #1;
        chk("ex_ctrl", ex_word(), m_ctrl);
        chk("ex_illegal", bus.ex_illegal, m_ill);
        chk("ex_pc4", bus.ex_pc4, m_pc4);
        chk("ex_rd1", bus.ex_rd1, m_rd1);
        chk("ex_rd2", bus.ex_rd2, m_rd2);
        chk("ex_imm", bus.ex_imm, m_imm);
        chk("ex_rs", bus.ex_rs, m_rs);
        chk("ex_rt", bus.ex_rt, m_rt);
        chk("ex_rd", bus.ex_rd, m_rd);
        chk("stall_count", stall_count, 64'(m_cnt));
        @(negedge clk);
    endtask

    initial begin
        flush = 1'b0; stat_clr = 1'b0; flush_s = 1'b0; stat_clr_s = 1'b0;
        set_instr(6'd0, 9'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        bus_s.id_opcode = 6'd3;
        {bus_s.id_reg_dst, bus_s.id_branch, bus_s.id_mem_read, bus_s.id_mem_to_reg,
         bus_s.id_mem_write, bus_s.id_alu_src, bus_s.id_reg_write, bus_s.id_alu_op} = C_LW;
        bus_s.id_rs = 5'd1; bus_s.id_rt = 5'd1; bus_s.id_rd = 5'd0;
        bus_s.id_pc4 = '0; bus_s.id_rd1 = '0; bus_s.id_rd2 = '0; bus_s.id_imm = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_ctrl", ex_word(), 9'd0);
        chk("reset_count", stall_count, 16'd0);
        chk("reset_pc_write", pc_write, 1'b1);

        // Pass-through of an I-type
        set_instr(6'd5, C_ITYPE, 5'd2, 5'd7, 5'd0, 32'h1234, 32'hFFFF_FFF0);
        cycle();
        chk("pt_alu_src", bus.ex_alu_src, 1'b1);
        chk("pt_reg_write", bus.ex_reg_write, 1'b1);
        chk("pt_alu_op", bus.ex_alu_op, 2'd2);
        chk("pt_rd1", bus.ex_rd1, 32'h1234);
        chk("pt_imm", bus.ex_imm, 32'hFFFF_FFF0);
        chk("pt_rt", bus.ex_rt, 5'd7);

        // Load-use: exactly one bubble
        set_instr(6'd3, C_LW, 5'd1, 5'd3, 5'd0, 32'd0, 32'd8);
        cycle();
        set_instr(6'd0, C_ADD, 5'd3, 5'd4, 5'd5, 32'd0, 32'd0);
        #1;
        chk("lu_pc_write_low", pc_write, 1'b0);
        chk("lu_ifid_low", ifid_write, 1'b0);
        cycle();
        chk("lu_bubble", ex_word(), 9'd0);
        chk("lu_count", stall_count, 16'd1);
        #1;
        chk("lu_pc_write_back", pc_write, 1'b1);
        cycle();
        chk("lu_add_ctrl", ex_word(), C_ADD);
        chk("lu_add_rs", bus.ex_rs, 5'd3);

        // Load into $zero never stalls
        set_instr(6'd3, C_LW, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0);
        cycle();
        set_instr(6'd0, C_ADD, 5'd0, 5'd0, 5'd6, 32'd0, 32'd0);
        #1;
        chk("zero_pc_write", pc_write, 1'b1);
        cycle();
        chk("zero_count", stall_count, 16'd1);

        // Flush beats a hazard
        set_instr(6'd3, C_LW, 5'd1, 5'd3, 5'd0, 32'd0, 32'd0);
        cycle();
        set_instr(6'd0, C_ADD, 5'd3, 5'd4, 5'd5, 32'd0, 32'd0);
        flush = 1'b1;
        #1;
        chk("fl_pc_write", pc_write, 1'b1);
        cycle();
        flush = 1'b0;
        chk("fl_ctrl", ex_word(), 9'd0);
        chk("fl_count", stall_count, 16'd1);

        // Clear wins over an increment
        set_instr(6'd3, C_LW, 5'd1, 5'd3, 5'd0, 32'd0, 32'd0);
        cycle();
        set_instr(6'd0, C_ADD, 5'd9, 5'd3, 5'd5, 32'd0, 32'd0);
        stat_clr = 1'b1;
        cycle();
        stat_clr = 1'b0;
        chk("clr_count", stall_count, 16'd0);
        cycle();

        // Illegal opcode becomes a flagged NOP
        set_instr(6'd13, 9'h1FF, 5'd8, 5'd9, 5'd10, 32'd0, 32'd0);
        cycle();
        chk("ill_flag", bus.ex_illegal, 1'b1);
        chk("ill_ctrl", ex_word(), 9'd0);

        for (int i = 0; i < 400; i++) begin
            rand_instr();
            flush = ($urandom_range(0, 7) == 0);
            stat_clr = ($urandom_range(0, 31) == 0);
            cycle();
        end
        flush = 1'b0; stat_clr = 1'b0;
        chk("sat_count", stall_count_s, 3'd7);

        // Build a count of 5 then reset asynchronously with a writing instruction in EX
        stat_clr = 1'b1;
        set_instr(6'd0, C_ADD, 5'd10, 5'd11, 5'd12, 32'd0, 32'd0);
        cycle();
        stat_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_instr(6'd3, C_LW, 5'd1, 5'd3, 5'd0, 32'd0, 32'd0);
            cycle();
            set_instr(6'd0, C_ADD, 5'd3, 5'd4, 5'd5, 32'd0, 32'd0);
            cycle();
        end
        cycle();
        chk("pre_rst_count", stall_count, 16'd5);
        chk("pre_rst_reg_write", bus.ex_reg_write, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ctrl", ex_word(), 9'd0);
        chk("arst_illegal", bus.ex_illegal, 1'b0);
        chk("arst_rd1", bus.ex_rd1, 32'd0);
        chk("arst_rt", bus.ex_rt, 5'd0);
        chk("arst_count", stall_count, 16'd0);
        chk("arst_pc_write", pc_write, 1'b1);
        chk("arst_ifid_write", ifid_write, 1'b1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset landing in the middle of a stall leaves nothing pending
        set_instr(6'd3, C_LW, 5'd1, 5'd3, 5'd0, 32'd0, 32'd0);
        cycle();
        set_instr(6'd0, C_ADD, 5'd3, 5'd4, 5'd5, 32'd0, 32'd0);
        #2;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_stall_pc_write", pc_write, 1'b1);
        cycle();
        chk("mid_stall_add", ex_word(), C_ADD);

        for (int i = 0; i < 100; i++) begin
            rand_instr();
            flush = ($urandom_range(0, 7) == 0);
            cycle();
        end
        chk("sat_count_again", stall_count_s, 3'd7);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
